// File: rtl/pad_event_encoder.sv
// Launchpad pad event encoder: picks the lowest pressed pad, debounces press and
// release, and emits a hold level plus start/end pulses. Optional macro: PAD_EVENT_HOLD_TIMEOUT_EN.
module pad_event_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pad_raw,
  output logic        button_inp,
  output logic [3:0]  event_id,
  output logic        event_start,
  output logic        event_end,
  output logic        busy
);

  localparam int unsigned PAD_W  = 16;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned HOLD_W = 16;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_FULL = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("pad_event_encoder: DEBOUNCE_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("pad_event_encoder: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    ACTIVE     = 3'd2,
    RELEASE_DB = 3'd3,
    LOCKOUT    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             button_q, button_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             busy_q, busy_d;

  logic [ID_W-1:0]  low_idx;
  logic             sel_pad;
  logic [CNT_W-1:0] cnt_inc;

`ifdef PAD_EVENT_HOLD_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(TIMEOUT_CYCLES);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_inc;
`endif

  // Lowest-index pressed pad wins a simultaneous press
  always_comb begin
    low_idx = '0;
    for (int i = PAD_W - 1; i >= 0; i--) begin
      if (pad_raw[i]) low_idx = ID_W'(i);
    end
  end

  assign sel_pad = pad_raw[id_q];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef PAD_EVENT_HOLD_TIMEOUT_EN
  assign hold_inc = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + HOLD_W'(1);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    button_d = button_q;
    start_d  = 1'b0;
    end_d    = 1'b0;
`ifdef PAD_EVENT_HOLD_TIMEOUT_EN
    hold_d   = hold_q;
`endif

    case (state_q)
      IDLE: begin
        if (|pad_raw) begin
          id_d    = low_idx;
          cnt_d   = '0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!sel_pad) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d  = ACTIVE;
          button_d = 1'b1;
          start_d  = 1'b1;
`ifdef PAD_EVENT_HOLD_TIMEOUT_EN
          hold_d   = '0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ACTIVE: begin
        if (!sel_pad) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (sel_pad) begin
          state_d = ACTIVE;
        end else if (cnt_q == DB_LAST) begin
          state_d  = IDLE;
          button_d = 1'b0;
          end_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOCKOUT: begin
        // Wait for DEBOUNCE_CYCLES+1 consecutive low samples of the held pad
        if (sel_pad) begin
          cnt_d = '0;
        end else if (cnt_q == DB_FULL) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d  = IDLE;
        button_d = 1'b0;
      end
    endcase

`ifdef PAD_EVENT_HOLD_TIMEOUT_EN
    // Hold timeout overrides a pending hold, but a completed release already ends the event
    if (state_q == ACTIVE || state_q == RELEASE_DB) begin
      hold_d = hold_inc;
      if (hold_inc == HOLD_LIMIT && state_d != IDLE) begin
        state_d  = LOCKOUT;
        button_d = 1'b0;
        end_d    = 1'b1;
        cnt_d    = '0;
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      id_q     <= '0;
      button_q <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef PAD_EVENT_HOLD_TIMEOUT_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      button_q <= button_d;
      start_q  <= start_d;
      end_q    <= end_d;
      busy_q   <= busy_d;
`ifdef PAD_EVENT_HOLD_TIMEOUT_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign button_inp  = button_q;
  assign event_id    = id_q;
  assign event_start = start_q;
  assign event_end   = end_q;
  assign busy        = busy_q;

endmodule

// File: doc/pad_event_encoder.md
PAD_EVENT_ENCODER -- requirements
Module: pad_event_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, extra consecutive stable samples required after the first (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum hold length in cycles when the timeout feature is compiled in (range 2..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pad_raw  input  16  raw, undebounced launchpad pad levels; 1 = pressed.
REQ-006 SHALL have port button_inp  output  1  debounced hold level for the selected pad; drives the LED event blocks.
REQ-007 SHALL have port event_id  output  4  index of the pad that owns the current event.
REQ-008 SHALL have port event_start  output  1  one-cycle pulse when button_inp rises.
REQ-009 SHALL have port event_end  output  1  one-cycle pulse when button_inp falls.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, PRESS_DB, ACTIVE, RELEASE_DB and LOCKOUT; all outputs registered.
REQ-012 IDLE: any pad_raw bit high -> latch lowest set index into event_id, clear debounce counter, go PRESS_DB.
REQ-013 PRESS_DB: pad_raw[event_id] low -> IDLE, no pulses. High with counter = DEBOUNCE_CYCLES-1 -> ACTIVE. Otherwise counter+1.
REQ-014 button_inp and event_start SHALL rise on the edge that samples the selected pad high for the (DEBOUNCE_CYCLES+1)th consecutive time; event_start is high for that one cycle only.
REQ-015 ACTIVE: button_inp = 1. Selected pad low -> RELEASE_DB with counter cleared. pad_raw bits other than event_id are ignored.
REQ-016 RELEASE_DB: button_inp stays 1. Selected pad high -> ACTIVE, no pulses. Low with counter = DEBOUNCE_CYCLES-1 -> IDLE, button_inp 0, event_end pulse on the same edge. Otherwise counter+1.
REQ-017 event_id SHALL hold its value from latch until the next IDLE selection.
REQ-018 Simultaneous presses SHALL be resolved by lowest index, and only in IDLE.
REQ-019 Any pad change during PRESS_DB, ACTIVE or RELEASE_DB SHALL NOT alter event_id.
REQ-020 event_start and event_end SHALL never be high in the same cycle.
REQ-021 Debounce counter SHALL be 8 bits and saturate, never wrap.

Reset
REQ-022 rst high at a clock edge SHALL force IDLE, counters 0, button_inp/event_start/event_end/busy = 0, event_id = 0.
REQ-023 Reset mid-event SHALL drop button_inp without an event_end pulse.
REQ-024 Reset has priority over all transitions; first non-reset edge evaluates from IDLE.

Configuration
REQ-025 Macro PAD_EVENT_HOLD_TIMEOUT_EN defined: a 16-bit hold counter SHALL clear on entry to ACTIVE from PRESS_DB, increment every cycle in ACTIVE/RELEASE_DB, and on reaching TIMEOUT_CYCLES force LOCKOUT with button_inp 0 and one event_end pulse.
REQ-026 LOCKOUT: button_inp 0. Return to IDLE only after the selected pad is sampled low DEBOUNCE_CYCLES+1 consecutive times. No event_start may occur meanwhile.
REQ-027 Macro undefined: no hold counter, LOCKOUT unreachable, hold length unbounded.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-028 pad_raw[5] high 20 cycles then low -> event_start 1 cycle after 5th high sample, event_id=5, button_inp high, event_end 1 cycle after 5th low sample.
REQ-029 pad_raw[2] high 3 cycles, low, high 3 cycles, low -> no event_start, button_inp stays 0, back to IDLE.
REQ-030 pad_raw = 0x0090 in same cycle -> event_id=4. Later pad 7 alone toggled during hold -> no effect.
REQ-031 During hold, pad glitches low 2 cycles -> button_inp stays 1, no event_end.
REQ-032 rst asserted 10 cycles into hold -> button_inp 0 next edge, event_end stays 0, busy 0.
REQ-033 With PAD_EVENT_HOLD_TIMEOUT_EN, pad held 200 cycles -> event_end after 64 active cycles, then no event_start until release plus 5 low samples. Without macro, button_inp high all 200 cycles.
